bpsk_module: RTL and testbench
==============================

// Module: bpsk_module
// PURPOSE
//  BPSK modulator. Serialises a DATA_WIDTH-bit word (MSB first) onto a square-wave carrier
//  derived from the system clock. Each bit lasts CYCLE_COUNT carrier periods.
//  Sits between the RAM/UART controller and the wave output pin.
//  Requests the next word via a one-clock data_finish pulse.
// PARAMETERS
//  CLOCK_IN       12_000_000  system clock frequency, Hz
//  CLOCK_CARRIER  6_400       carrier frequency, Hz
//  DATA_WIDTH     8           bits per word
//  CYCLE_COUNT    2           carrier periods per bit (>=1)
//  FINISH_LEAD    2           clocks before word end at which data_finish fires (1..W-1)
// PORTS
//  clk          in   1           system clock, rising edge
//  n_rst        in   1           asynchronous, active-low reset
//  data_in      in   DATA_WIDTH  word to transmit; sampled only at word start
//  wave_out     out  1           modulated carrier (registered)
//  data_finish  out  1           one-clock pulse: next word about to be latched (registered)
// BEHAVIOUR
//  - HALF = CLOCK_IN/(2*CLOCK_CARRIER), integer floor, >=1 (12e6/12800 -> 937).
//    Carrier period = 2*HALF clocks; bit time B = 2*HALF*CYCLE_COUNT; word time W = DATA_WIDTH*B.
//  - Reset (n_rst=0, async): wave_out=0, data_finish=0, all counters 0, shift reg 0.
//  - First rising edge after reset release is edge 0 of word 0:
//    data_in is latched into the shift register and the MSB becomes the current bit.
//  - Reference carrier within each carrier period: 1 for HALF clocks, then 0 for HALF clocks.
//    Phase restarts at every bit boundary.
//  - wave_out = carrier when the current bit is 1; wave_out = ~carrier when the bit is 0.
//    Values take effect from the edge that starts the bit.
//  - Bit k (k=0 is MSB) occupies edges k*B .. k*B+B-1 of the word.
//    After the last bit, edge W is edge 0 of the next word: re-latch data_in, no idle gap.
//  - data_finish is high for exactly one clock, registered at edge W-FINISH_LEAD of each word.
//    This leaves the controller time to step the RAM address (1-cycle read latency) before edge W.
//  - data_in changes between word starts are ignored.
//  - Reset asserted mid-word: immediate clear. After release, restart at word 0 edge 0, MSB first.
//  - Counters wrap cleanly. HALF counter width = $clog2(HALF+1); bit index width = $clog2(DATA_WIDTH).
// CONFIGURATION
//  BPSK_DIFF_EN defined: differential BPSK.
//   - A transmitted phase register starts at 0 on reset.
//   - At each bit start, the register toggles if the bit is 1 and holds if it is 0.
//   - wave_out = carrier ^ phase.
//  BPSK_DIFF_EN undefined: absolute BPSK as described above. No phase register is synthesised.
// STRUCTURE
//  - Package bpsk_pkg: function calc_half(clock_in, clock_carrier); localparam helpers for B and W;
//    typedef of the state enum {LATCH, RUN}.
//  - One sub-module, bpsk_carrier_gen: HALF counter and cycle counter.
//    Outputs: carrier, carrier_period_end, bit_end.
//  - The top level holds the shift register, bit index, data_finish and wave_out registers.
// TESTING (CLOCK_IN=16, CLOCK_CARRIER=2, CYCLE_COUNT=2, DATA_WIDTH=8 -> HALF=4, B=16, W=128)
//  1. n_rst=0 with clk running -> wave_out=0, data_finish=0 throughout.
//  2. data_in=8'hFF -> wave_out is 1111_0000 repeating for all 128 clocks, with no phase inversion.
//  3. data_in=8'h80 -> clocks 0-15: 1111_0000_1111_0000. Clocks 16-127: 0000_1111 repeating.
//  4. data_finish pulses once per word, at edge 126, 254, ...
//     Change data_in at edge 60 -> no effect until edge 128, where the new word appears.
//  5. Pull n_rst low at edge 50 -> outputs 0 asynchronously.
//     Release -> pattern restarts from MSB, and the first data_finish is again at edge 126.
//  6. With BPSK_DIFF_EN and data_in=8'hC0:
//     bits 0-1 -> phase toggles, so bit 0 is inverted and bit 1 is normal;
//     bits 2-7 -> phase held, so they stay normal.

Source files
------------

// File: rtl/bpsk_pkg.sv
// Shared types and timing helpers for the BPSK modulator.
package bpsk_pkg;

    typedef enum logic {
        LATCH = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Half carrier period in system clocks, floored and never below one.
    function automatic int calc_half(input int clock_in, input int clock_carrier);
        int h;
        h = clock_in / (2 * clock_carrier);
        return (h < 1) ? 1 : h;
    endfunction

    function automatic int calc_bit_time(input int half, input int cycle_count);
        return 2 * half * cycle_count;
    endfunction

    function automatic int calc_word_time(input int bit_time, input int data_width);
        return bit_time * data_width;
    endfunction

    function automatic int calc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bpsk_if.sv
// Word/handshake bundle between the RAM/UART controller and the BPSK modulator.
interface bpsk_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  wave_out;
    logic                  data_finish;

    modport master (
        output data_in,
        input  wave_out,
        input  data_finish
    );

    modport slave (
        input  data_in,
        output wave_out,
        output data_finish
    );
endinterface

// File: rtl/bpsk_carrier_gen.sv
// Square-wave carrier timing: half-period counter and carrier-cycle counter.
// Also flags a fixed clock offset within each bit for the word-end request.
module bpsk_carrier_gen
    import bpsk_pkg::*;
#(
    parameter int HALF        = 937,
    parameter int CYCLE_COUNT = 2,
    parameter int HIT_OFFSET  = 0
) (
    input  logic clk,
    input  logic n_rst,
    output logic carrier_o,
    output logic carrier_period_end_o,
    output logic bit_end_o,
    output logic offset_hit_o
);
    localparam int   HALF_W   = $clog2(HALF + 1);
    localparam int   CYC_W    = calc_width(CYCLE_COUNT);
    localparam int   PERIOD_T = 2 * HALF;
    localparam int   HIT_CYC  = HIT_OFFSET / PERIOD_T;
    localparam int   HIT_REM  = HIT_OFFSET % PERIOD_T;
    localparam logic HIT_LOW  = (HIT_REM >= HALF);
    localparam int   HIT_HALF = HIT_LOW ? (HIT_REM - HALF) : HIT_REM;

    logic [HALF_W-1:0] halfCnt_q, halfCnt_d;
    logic              low_q, low_d;
    logic [CYC_W-1:0]  cycCnt_q, cycCnt_d;
    logic              halfEnd;

    always_comb begin
        halfEnd              = (halfCnt_q == HALF_W'(HALF - 1));
        carrier_period_end_o = halfEnd & low_q;
        bit_end_o            = carrier_period_end_o & (cycCnt_q == CYC_W'(CYCLE_COUNT - 1));
        halfCnt_d            = halfEnd ? '0 : halfCnt_q + 1'b1;
        low_d                = low_q ^ halfEnd;
        cycCnt_d             = cycCnt_q;
        if (bit_end_o) begin
            cycCnt_d = '0;
        end else if (carrier_period_end_o) begin
            cycCnt_d = cycCnt_q + 1'b1;
        end
    end

    // Counters always sit at the position of the upcoming edge; high half comes first.
    assign carrier_o    = ~low_q;
    assign offset_hit_o = (cycCnt_q == CYC_W'(HIT_CYC)) && (low_q == HIT_LOW) &&
                          (halfCnt_q == HALF_W'(HIT_HALF));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            halfCnt_q <= '0;
            low_q     <= 1'b0;
            cycCnt_q  <= '0;
        end else begin
            halfCnt_q <= halfCnt_d;
            low_q     <= low_d;
            cycCnt_q  <= cycCnt_d;
        end
    end

endmodule

// File: rtl/bpsk_module.sv
// BPSK modulator: serialises words MSB first onto a clock-derived square carrier.
// Define BPSK_DIFF_EN for differential BPSK (phase toggles on every 1 bit).
module bpsk_module
    import bpsk_pkg::*;
#(
    parameter int CLOCK_IN      = 12_000_000,
    parameter int CLOCK_CARRIER = 6_400,
    parameter int DATA_WIDTH    = 8,
    parameter int CYCLE_COUNT   = 2,
    parameter int FINISH_LEAD   = 2
) (
    input logic   clk,
    input logic   n_rst,
    bpsk_if.slave bus
);
    localparam int HALF     = calc_half(CLOCK_IN, CLOCK_CARRIER);
    localparam int BIT_T    = calc_bit_time(HALF, CYCLE_COUNT);
    localparam int WORD_T   = calc_word_time(BIT_T, DATA_WIDTH);
    localparam int IDX_W    = calc_width(DATA_WIDTH);
    localparam int TARGET   = WORD_T - FINISH_LEAD;
    localparam int T_BIT    = TARGET / BIT_T;
    localparam int T_OFFSET = TARGET % BIT_T;

    logic carrier, periodEnd, bitEnd, offsetHit;

    bpsk_carrier_gen #(
        .HALF        (HALF),
        .CYCLE_COUNT (CYCLE_COUNT),
        .HIT_OFFSET  (T_OFFSET)
    ) u_carrier (
        .clk                  (clk),
        .n_rst                (n_rst),
        .carrier_o            (carrier),
        .carrier_period_end_o (periodEnd),
        .bit_end_o            (bitEnd),
        .offset_hit_o         (offsetHit)
    );

    logic unusedPeriodEnd;
    assign unusedPeriodEnd = periodEnd;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      bitIdx_q, bitIdx_d;
    logic                  wave_q, wave_d;
    logic                  finish_q, finish_d;
    logic                  curBit;

    // In LATCH the word is taken straight from the bus so its MSB drives edge 0.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitIdx_d = bitIdx_q;
        curBit   = (state_q == LATCH) ? bus.data_in[DATA_WIDTH-1] : shift_q[DATA_WIDTH-1];
        if (state_q == LATCH) begin
            shift_d = bus.data_in;
            state_d = RUN;
        end
        if (bitEnd) begin
            shift_d = shift_d << 1;
            if (bitIdx_q == IDX_W'(DATA_WIDTH - 1)) begin
                bitIdx_d = '0;
                state_d  = LATCH;
            end else begin
                bitIdx_d = bitIdx_q + 1'b1;
            end
        end
        finish_d = offsetHit && (bitIdx_q == IDX_W'(T_BIT));
    end

`ifdef BPSK_DIFF_EN
    logic phase_q, phase_d, bitStart_q;

    always_comb begin
        phase_d = phase_q;
        if (bitStart_q) begin
            phase_d = phase_q ^ curBit;
        end
        wave_d = carrier ^ phase_d;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase_q    <= 1'b0;
            bitStart_q <= 1'b1;
        end else begin
            phase_q    <= phase_d;
            bitStart_q <= bitEnd;
        end
    end
`else
    always_comb begin
        wave_d = carrier ^ ~curBit;
    end
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= LATCH;
            shift_q  <= '0;
            bitIdx_q <= '0;
            wave_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitIdx_q <= bitIdx_d;
            wave_q   <= wave_d;
            finish_q <= finish_d;
        end
    end

    assign bus.wave_out    = wave_q;
    assign bus.data_finish = finish_q;

endmodule

// File: tb/tb_bpsk_module.sv
// Scoreboard bench for bpsk_module with HALF=4, B=16, W=128.
module tb_bpsk_module;

    localparam int HALF   = 4;
    localparam int BIT_T  = 16;
    localparam int WORD_T = 128;

    typedef struct {
        int   edgeNum;
        logic wave;
        logic finish;
    } exp_t;

    logic clk = 1'b0;
    logic nRst;

    bpsk_if #(.DATA_WIDTH(8)) bus ();

    bpsk_module #(
        .CLOCK_IN      (16),
        .CLOCK_CARRIER (2),
        .DATA_WIDTH    (8),
        .CYCLE_COUNT   (2),
        .FINISH_LEAD   (2)
    ) dut (
        .clk   (clk),
        .n_rst (nRst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t       expQ[$];
    int         checks = 0;
    int         errors = 0;
    int         modelEdge = 0;
    logic [7:0] modelWord = 8'h00;
`ifdef BPSK_DIFF_EN
    logic       modelPhase = 1'b0;
`endif

    task automatic checkOutput(input string name, input int edgeNum, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s edge %0d got %0b want %0b", name, edgeNum, got, want);
        end
    endtask

    // One clock: the model sees the same data_in the DUT samples on this edge.
    task automatic applyStimulus();
        exp_t e;
        int   p;
        logic b;
        logic car;
        @(posedge clk);
        if (!nRst) begin
            e.edgeNum = -1;
            e.wave    = 1'b0;
            e.finish  = 1'b0;
            modelEdge = 0;
`ifdef BPSK_DIFF_EN
            modelPhase = 1'b0;
`endif
        end else begin
            p = modelEdge % WORD_T;
            if (p == 0) modelWord = bus.data_in;
            b   = modelWord[7 - p / BIT_T];
            car = ((p % (2 * HALF)) < HALF);
`ifdef BPSK_DIFF_EN
            if (p % BIT_T == 0) modelPhase = modelPhase ^ b;
            e.wave = car ^ modelPhase;
`else
            e.wave = b ? car : ~car;
`endif
            e.finish  = (p == WORD_T - 2);
            e.edgeNum = modelEdge;
            modelEdge++;
        end
        expQ.push_back(e);
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("wave_out", e.edgeNum, bus.wave_out, e.wave);
            checkOutput("data_finish", e.edgeNum, bus.data_finish, e.finish);
        end
    end

    initial begin
        $display("[TB] start");
        nRst        = 1'b0;
        bus.data_in = 8'hFF;
        repeat (4) applyStimulus();
        @(negedge clk);
        #1 nRst = 1'b1;

        for (int i = 0; i < WORD_T; i++) begin
            applyStimulus();
            if (i == 60) #1 bus.data_in = 8'h80;
        end
        for (int i = 0; i < WORD_T; i++) begin
            applyStimulus();
            if (i == 60) #1 bus.data_in = 8'h5A;
        end
        for (int i = 0; i <= 50; i++) begin
            applyStimulus();
        end

        @(negedge clk);
        #1 nRst = 1'b0;
        #1;
        checkOutput("async_reset_wave", -1, bus.wave_out, 1'b0);
        checkOutput("async_reset_finish", -1, bus.data_finish, 1'b0);
        bus.data_in = 8'hA5;
        repeat (3) applyStimulus();
        @(negedge clk);
        #1 nRst = 1'b1;

        for (int i = 0; i < WORD_T + 2; i++) begin
            applyStimulus();
            if (i == 60) #1 bus.data_in = 8'h3C;
        end
        @(negedge clk);
        #2;
        checkOutput("queue_drained", -1, (expQ.size() == 0), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
